// File: rtl/seq_mul_pkg.sv
// ----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - state_t        : controller states (IDLE, RUN, DONE)
//   - SEQ_MUL_WIDTH  : default operand width
//   - cnt_width()    : width of the step counter for a given operand width
// ----------------------------------------------------------------------------
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SEQ_MUL_WIDTH = 16;

   // One extra bit over $clog2 so the counter can hold WIDTH itself; the
   // alignment shift amount (WIDTH - cnt) is formed at this same width.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage : seq_mul_pkg

// File: rtl/mul_add_stage.sv
// ----------------------------------------------------------------------------
// mul_add_stage
// WIDTH-bit ripple-carry adder used once per multiply step for hi + addend.
// Carry-in is tied low; the carry-out is exposed so the multiplier keeps the
// full WIDTH+1-bit partial sum.
//
// Ports:
//   a      in   WIDTH  first addend (running high half)
//   b      in   WIDTH  second addend (multiplicand or zero)
//   sum    out  WIDTH  a + b, low WIDTH bits
//   c_out  out  1      carry out of the top bit
// ----------------------------------------------------------------------------
module mul_add_stage #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   logic carry;

   // Bit-serial carry ripple expressed as a loop so the chain stays one
   // combinational variable rather than a self-referencing vector.
   always_comb begin
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule : mul_add_stage

// File: rtl/seq_mul16.sv
// ----------------------------------------------------------------------------
// seq_mul16
// Sequential unsigned shift-and-add multiplier with valid/ready on both the
// operand and the result side. One WIDTH-bit add per clock builds the
// 2*WIDTH-bit product over WIDTH steps.
//
// Build option:
//   SEQ_MUL16_EARLY_EXIT_EN  when defined, RUN ends as soon as the remaining
//                            multiplier bits are all zero, finishing with a
//                            single alignment shift. Result is unchanged.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        operands a/b valid
//   in_ready   out  1        block can accept operands (IDLE)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   out_valid  out  1        product p valid (DONE)
//   out_ready  in   1        consumer accepts p
//   p          out  2*WIDTH  unsigned product a*b, held while in DONE
//   busy       out  1        high in RUN or DONE
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for operands, in_ready=1
// RUN   | one shift-and-add step per clock, cnt counts steps taken
// DONE  | product on p with out_valid=1 until out_ready is seen
// ----------------------------------------------------------------------------
module seq_mul16
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = SEQ_MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               c_out;
   logic [2*WIDTH-1:0] step_prod;

   assign addend = lo[0] ? mcand : '0;

   mul_add_stage #(
      .WIDTH (WIDTH)
   ) u_add (
      .a     (hi),
      .b     (addend),
      .sum   (sum),
      .c_out (c_out)
   );

   // {c,sum,lo} >> 1: the carry becomes the new MSB of hi, the add's LSB
   // drops into the top of lo, and the consumed multiplier bit falls off.
   assign step_prod = {c_out, sum, lo[WIDTH-1:1]};

`ifdef SEQ_MUL16_EARLY_EXIT_EN
   // Multiplier bits not yet consumed. Once these are all zero every
   // remaining step would add zero, so the outstanding WIDTH-cnt shifts
   // collapse into one.
   logic [WIDTH-1:0]   rem;
   logic [CNT_W-1:0]   align_sh;
   logic [2*WIDTH-1:0] align_prod;

   assign align_sh   = CNT_W'(WIDTH) - cnt;
   assign align_prod = {hi, lo} >> align_sh;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         p         <= '0;
         mcand     <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
`ifdef SEQ_MUL16_EARLY_EXIT_EN
         rem       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= a;
                  lo       <= b;
                  hi       <= '0;
                  cnt      <= '0;
`ifdef SEQ_MUL16_EARLY_EXIT_EN
                  rem      <= b;
`endif
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            RUN: begin
`ifdef SEQ_MUL16_EARLY_EXIT_EN
               if (rem == '0) begin
                  {hi, lo}  <= align_prod;
                  p         <= align_prod;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  {hi, lo} <= step_prod;
                  rem      <= rem >> 1;
                  cnt      <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     p         <= step_prod;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
`else
               {hi, lo} <= step_prod;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  p         <= step_prod;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
`endif
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule : seq_mul16

// File: doc/seq_mul16.md
Name: seq_mul16

Overview:
- Sequential shift-and-add unsigned multiplier in the ALU datapath.
- Sits downstream of the 16-bit ripple-carry adder stage and reuses one WIDTH-bit add per cycle to build a 2*WIDTH-bit product.
- Valid/ready handshake on the operand side and on the result side, so it drops into the ALU pipeline.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product p valid.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  unsigned product a*b.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, so in_ready=1 after reset.
  - out_valid=0, busy=0.
  - p=0; internal mcand, hi, lo and cnt all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge when in_valid&in_ready: mcand<=a, lo<=b, hi<=0, cnt<=0; go to RUN.
- RUN, one step per edge:
  - {c,sum} = hi + (lo[0] ? mcand : 0), computed with WIDTH-bit add and carry-out.
  - {hi,lo} <= {c,sum,lo} >> 1.
  - cnt<=cnt+1.
  - After the step with cnt==WIDTH-1, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1, p={hi,lo}.
  - On the edge where out_ready=1, go to IDLE, out_valid falls.
  - p is held stable while out_ready=0.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge (16 for the default).
- Throughput: one product per WIDTH+2 cycles at minimum.
- Arithmetic: the carry out of the add is never dropped. The result is exact for all inputs, e.g. 0xFFFF*0xFFFF=0xFFFE0001.
- in_valid while busy: ignored (in_ready=0). Operands are captured only at the accept edge; later changes to a/b have no effect.
- out_ready high outside DONE: no effect.
- Reset mid-RUN or mid-DONE: immediate return to IDLE, out_valid=0, p=0. The partial result is discarded.
- cnt width: $clog2(WIDTH)+1 bits; cnt never wraps.

Optional Feature:
- Macro: SEQ_MUL16_EARLY_EXIT_EN.
- Defined:
  - In RUN, a separate shift register holds the not-yet-consumed multiplier bits.
  - If those bits are all zero at the start of a step, do a single alignment step {hi,lo} <= {hi,lo} >> (WIDTH-cnt) and go to DONE.
  - If b==0 at accept, RUN lasts 1 cycle.
  - Latency becomes (index of the highest set bit of b)+2 cycles, max WIDTH.
  - Result is identical to the non-early-exit result.
- Not defined: fixed WIDTH-cycle latency as above; the extra register and shifter are not built.

Decomposition:
- Package seq_mul_pkg:
  - state enum (IDLE, RUN, DONE).
  - default WIDTH constant.
  - CNT_W derivation function.
- Sub-module mul_add_stage: WIDTH-bit ripple-carry adder with c_in tied 0 and c_out exposed. It is instantiated once for the hi + mcand add.

Test Plan:
- a=3, b=5, out_ready=1 -> out_valid exactly 16 cycles after accept, p=0x0000000F, then in_ready=1 the next cycle.
- a=0xFFFF, b=0xFFFF -> p=0xFFFE0001 (carry path exercised every step).
- a=0x1234, b=0x0002, out_ready held 0 for 10 cycles -> out_valid and p=0x00002468 stable throughout, single handshake.
- Accept a=7, b=9, then toggle a/b and hold in_valid=1 during RUN -> in_ready=0, p=0x0000003F, no second accept until IDLE.
- Assert rst for 1 cycle at RUN cycle 8 -> out_valid=0, p=0, in_ready=1 asynchronously. A subsequent a=2, b=2 gives p=4.
- With SEQ_MUL16_EARLY_EXIT_EN: a=0xABCD, b=1 -> p=0x0000ABCD after 2 cycles. b=0 -> p=0 after 1 cycle. Random 1000 pairs match a*b.
